// File: rtl/ddr_ring_addr_gen.sv
// rtl/ddr_ring_addr_gen.sv - DDR ring-buffer burst address generator with block-level flow control
module ddr_ring_addr_gen #(
    parameter int ADDR_WIDTH  = 25,
    parameter int BURST_LEN   = 2,
    parameter int BLOCK_WORDS = 1024,
    parameter int NUM_BLOCKS  = 4,
    parameter int BASE_ADDR   = 0,
    parameter int OVERWRITE   = 0,
    parameter int CW          = $clog2(NUM_BLOCKS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_addr_up,
    input  logic                  rd_addr_up,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  write_en,
    output logic                  read_en,
    output logic [CW-1:0]         blocks_used,
    output logic                  wr_block_done,
    output logic                  rd_block_done,
    output logic                  drop,
    output logic                  wr_err,
    output logic                  rd_err
);

    localparam int OFF_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BLOCK_WORDS - BURST_LEN);
    localparam logic [OFF_W-1:0] OFF_STEP = OFF_W'(BURST_LEN);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NUM_BLOCKS - 1);
    localparam logic [CW-1:0]    USED_FULL = CW'(NUM_BLOCKS);

    logic [BLK_W-1:0] wr_blk, rd_blk, wr_blk_n, rd_blk_n;
    logic [OFF_W-1:0] wr_off, rd_off, wr_off_n, rd_off_n;
    logic [CW-1:0]    used, used_n;
    logic             wr_acc, rd_acc, wr_end, rd_end;
    logic             ovw, wr_err_n, rd_err_n;

    function automatic logic [ADDR_WIDTH-1:0] form_addr(input logic [BLK_W-1:0] blk,
                                                         input logic [OFF_W-1:0] off);
        return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(blk) * ADDR_WIDTH'(BLOCK_WORDS)
               + ADDR_WIDTH'(off);
    endfunction

    function automatic logic [BLK_W-1:0] blk_inc(input logic [BLK_W-1:0] blk);
        return (blk == BLK_LAST) ? '0 : blk + BLK_W'(1);
    endfunction

    // Next-state: step pointers on accepted strobes; a write into a full ring
    // (overwrite mode) evicts the block under the reader and swallows its strobe.
    always_comb begin
        wr_blk_n = wr_blk;
        rd_blk_n = rd_blk;
        wr_off_n = wr_off;
        rd_off_n = rd_off;
        used_n   = used;
        wr_end   = 1'b0;
        rd_end   = 1'b0;

        wr_acc   = wr_addr_up && write_en;
        wr_err_n = wr_addr_up && !write_en;
        ovw      = (OVERWRITE != 0) && wr_addr_up && (used == USED_FULL);
        rd_acc   = rd_addr_up && read_en && !ovw;
        rd_err_n = rd_addr_up && !read_en;

        if (wr_acc) begin
            if (wr_off == OFF_LAST) begin
                wr_off_n = '0;
                wr_blk_n = blk_inc(wr_blk);
                wr_end   = 1'b1;
            end else begin
                wr_off_n = wr_off + OFF_STEP;
            end
        end

        if (ovw) begin
            rd_off_n = '0;
            rd_blk_n = blk_inc(rd_blk);
        end else if (rd_acc) begin
            if (rd_off == OFF_LAST) begin
                rd_off_n = '0;
                rd_blk_n = blk_inc(rd_blk);
                rd_end   = 1'b1;
            end else begin
                rd_off_n = rd_off + OFF_STEP;
            end
        end

        case ({wr_end, rd_end || ovw})
            2'b10:   used_n = used + CW'(1);
            2'b01:   used_n = used - CW'(1);
            default: used_n = used;
        endcase
    end

    // State and registered outputs; reset wins over any strobe in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_blk        <= '0;
            rd_blk        <= '0;
            wr_off        <= '0;
            rd_off        <= '0;
            used          <= '0;
            wr_addr       <= ADDR_WIDTH'(BASE_ADDR);
            rd_addr       <= ADDR_WIDTH'(BASE_ADDR);
            write_en      <= 1'b1;
            read_en       <= 1'b0;
            wr_block_done <= 1'b0;
            rd_block_done <= 1'b0;
            drop          <= 1'b0;
            wr_err        <= 1'b0;
            rd_err        <= 1'b0;
        end else begin
            wr_blk        <= wr_blk_n;
            rd_blk        <= rd_blk_n;
            wr_off        <= wr_off_n;
            rd_off        <= rd_off_n;
            used          <= used_n;
            wr_addr       <= form_addr(wr_blk_n, wr_off_n);
            rd_addr       <= form_addr(rd_blk_n, rd_off_n);
            write_en      <= (OVERWRITE != 0) || (used_n != USED_FULL);
            read_en       <= (used_n != '0);
            wr_block_done <= wr_end;
            rd_block_done <= rd_end;
            drop          <= ovw;
            wr_err        <= wr_err_n;
            rd_err        <= rd_err_n;
        end
    end

    assign blocks_used = used;

endmodule
